// File: rtl/lgn_seq_pkg.sv
// Shared constants and state encoding for the LGN frame sequencer.
// The board top and the testbench use these so that they agree on frame geometry.
package lgn_seq_pkg;

    localparam int LGN_FRAME_BYTES    = 32;
    localparam int LGN_RESULT_LATENCY = 2;
    localparam int LGN_PAT_SEL_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STREAM,
        DRAIN,
        CAPTURE
    } seq_state_t;

    // Drain down-counter width; kept at least one bit so a zero latency still elaborates.
    function automatic int drain_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/lgn_frame_sequencer.sv
// Streams one binary image from a synchronous pattern ROM into the LGN core byte input,
// waits out the core result latency and captures class/score into held result registers.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet, results held
// FETCH   | address of byte 0 on the ROM bus
// STREAM  | one byte per cycle onto core_data, next address issued in parallel
// DRAIN   | core_data quiet, down-counter covers the core result latency
// CAPTURE | result_valid pulse; auto_run decides between FETCH and IDLE
module lgn_frame_sequencer
    import lgn_seq_pkg::*;
#(
    parameter int FRAME_BYTES    = LGN_FRAME_BYTES,
    parameter int RESULT_LATENCY = LGN_RESULT_LATENCY,
    parameter int PAT_SEL_W      = LGN_PAT_SEL_W
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    auto_run,
    input  logic [PAT_SEL_W-1:0]                    pat_sel,
    output logic [PAT_SEL_W+$clog2(FRAME_BYTES)-1:0] rom_addr,
    input  logic [7:0]                              rom_data,
    output logic [7:0]                              core_data,
    output logic                                    core_frame_sync,
    input  logic [3:0]                              core_index,
    input  logic [7:0]                              core_value,
    output logic                                    busy,
    output logic                                    result_valid,
    output logic [3:0]                              result_index,
    output logic [7:0]                              result_value,
    output logic [15:0]                             frame_count
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam int DRN_W = drain_width(RESULT_LATENCY);

    seq_state_t           state;
    logic [PAT_SEL_W-1:0] sel_q;
    logic [IDX_W-1:0]     byte_idx;
    logic [DRN_W-1:0]     drain_cnt;
    logic [15:0]          frame_cnt;

    // ROM address is the latched select plus the running byte index; ROM answers next cycle.
    assign rom_addr    = {sel_q, byte_idx};
    assign busy        = (state != IDLE);
    assign frame_count = frame_cnt;

    // Frame sequencing FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            sel_q           <= '0;
            byte_idx        <= '0;
            drain_cnt       <= '0;
            frame_cnt       <= '0;
            core_data       <= '0;
            core_frame_sync <= 1'b0;
            result_valid    <= 1'b0;
            result_index    <= '0;
            result_value    <= '0;
        end else begin
            core_data       <= '0;
            core_frame_sync <= 1'b0;
            result_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q    <= pat_sel;
                        byte_idx <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    byte_idx <= byte_idx + 1'b1;
                    state    <= STREAM;
                end
                STREAM: begin
                    // rom_data here belongs to the address issued one cycle earlier,
                    // so byte_idx == 1 means byte 0 is being loaded.
                    core_data       <= rom_data;
                    core_frame_sync <= (byte_idx == IDX_W'(1));
                    if (byte_idx == '0) begin
                        // Index has wrapped: this is the last byte of the frame.
                        drain_cnt <= DRN_W'(RESULT_LATENCY);
                        state     <= DRAIN;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        result_index <= core_index;
                        result_value <= core_value;
                        result_valid <= 1'b1;
                        frame_cnt    <= frame_cnt + 16'd1;
                        state        <= CAPTURE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    // auto_run takes precedence; start is only looked at in IDLE.
                    if (auto_run) begin
                        sel_q    <= pat_sel;
                        byte_idx <= '0;
                        state    <= FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// Scoreboard bench for lgn_frame_sequencer: default instance plus a RESULT_LATENCY=5 instance.
module tb_lgn_frame_sequencer;
    import lgn_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start_a, auto_run_a;
    logic [1:0]  pat_sel_a;
    logic [6:0]  rom_addr_a;
    logic [7:0]  rom_data_a, core_data_a, core_value_a, result_value_a;
    logic        core_frame_sync_a, busy_a, result_valid_a;
    logic [3:0]  core_index_a, result_index_a;
    logic [15:0] frame_count_a;

    logic        start_b, auto_run_b;
    logic [1:0]  pat_sel_b;
    logic [6:0]  rom_addr_b;
    logic [7:0]  rom_data_b, core_data_b, core_value_b, result_value_b;
    logic        core_frame_sync_b, busy_b, result_valid_b;
    logic [3:0]  core_index_b, result_index_b;
    logic [15:0] frame_count_b;

    lgn_frame_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .auto_run(auto_run_a), .pat_sel(pat_sel_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .core_data(core_data_a),
        .core_frame_sync(core_frame_sync_a), .core_index(core_index_a), .core_value(core_value_a),
        .busy(busy_a), .result_valid(result_valid_a), .result_index(result_index_a),
        .result_value(result_value_a), .frame_count(frame_count_a)
    );

    lgn_frame_sequencer #(.RESULT_LATENCY(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .auto_run(auto_run_b), .pat_sel(pat_sel_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .core_data(core_data_b),
        .core_frame_sync(core_frame_sync_b), .core_index(core_index_b), .core_value(core_value_b),
        .busy(busy_b), .result_valid(result_valid_b), .result_index(result_index_b),
        .result_value(result_value_b), .frame_count(frame_count_b)
    );

    // Pattern ROM contents: {select, byte index + 1}; never zero.
    function automatic logic [7:0] rom_fn(input logic [6:0] a);
        logic [5:0] k1;
        k1 = {1'b0, a[4:0]} + 6'd1;
        return {a[6:5], k1};
    endfunction

    always @(posedge clk) rom_data_a <= rom_fn(rom_addr_a);
    always @(posedge clk) rom_data_b <= rom_fn(rom_addr_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [8:0] word;
    } byte_exp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [7:0]  val;
        logic [15:0] fc;
    } res_exp_t;

    byte_exp_t   byte_q[$];
    res_exp_t    res_q_a[$];
    res_exp_t    res_q_b[$];
    logic [11:0] core_q_a[$];
    logic [11:0] core_q_b[$];

    // Core models: correct result only in the cycle before the capture edge, inverted otherwise.
    int          tgt_a = -1;
    int          tgt_b = -1;
    logic [11:0] good_a = '0;
    logic [11:0] good_b = '0;

    always @(negedge clk) begin
        if (core_frame_sync_a) begin
            tgt_a  = cyc + 33;
            good_a = (core_q_a.size() > 0) ? core_q_a.pop_front() : 12'h5A3;
        end
        if (cyc == tgt_a) {core_index_a, core_value_a} = good_a;
        else              {core_index_a, core_value_a} = ~good_a;
    end

    always @(negedge clk) begin
        if (core_frame_sync_b) begin
            tgt_b  = cyc + 36;
            good_b = (core_q_b.size() > 0) ? core_q_b.pop_front() : 12'h5A3;
        end
        if (cyc == tgt_b) {core_index_b, core_value_b} = good_b;
        else              {core_index_b, core_value_b} = ~good_b;
    end

    // Byte stream monitor for instance A.
    byte_exp_t be;
    always @(negedge clk) begin
        if (core_data_a != 8'd0 || core_frame_sync_a) begin
            if (byte_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_byte actual=%0h required=none cycle=%0d", core_data_a, cyc);
            end else begin
                be = byte_q.pop_front();
                chk("byte_cycle", cyc, be.cyc);
                chk("byte_sync_data", {core_frame_sync_a, core_data_a}, {23'd0, be.word});
            end
        end
    end

    // Result monitors.
    res_exp_t ra, rb;
    always @(negedge clk) begin
        if (result_valid_a) begin
            if (res_q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_result_a actual=1 required=0 cycle=%0d", cyc);
            end else begin
                ra = res_q_a.pop_front();
                chk("res_a_cycle", cyc, ra.cyc);
                chk("res_a_index", result_index_a, ra.idx);
                chk("res_a_value", result_value_a, ra.val);
                chk("res_a_count", frame_count_a, ra.fc);
            end
        end
    end

    always @(negedge clk) begin
        if (result_valid_b) begin
            if (res_q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_result_b actual=1 required=0 cycle=%0d", cyc);
            end else begin
                rb = res_q_b.pop_front();
                chk("res_b_cycle", cyc, rb.cyc);
                chk("res_b_index", result_index_b, rb.idx);
                chk("res_b_value", result_value_b, rb.val);
                chk("res_b_count", frame_count_b, rb.fc);
            end
        end
    end

    task automatic push_bytes(input int base, input logic [1:0] sel, input int n);
        byte_exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = base + 3 + k;
            e.word = {(k == 0), rom_fn({sel, 5'(k)})};
            byte_q.push_back(e);
        end
    endtask

    task automatic push_res_a(input int c, input logic [3:0] idx, input logic [7:0] val, input logic [15:0] fc);
        res_exp_t r;
        r.cyc = c; r.idx = idx; r.val = val; r.fc = fc;
        res_q_a.push_back(r);
        core_q_a.push_back({idx, val});
    endtask

    task automatic push_res_b(input int c, input logic [3:0] idx, input logic [7:0] val, input logic [15:0] fc);
        res_exp_t r;
        r.cyc = c; r.idx = idx; r.val = val; r.fc = fc;
        res_q_b.push_back(r);
        core_q_b.push_back({idx, val});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_core_data"}, core_data_a, 0);
        chk({tag, "_sync"}, core_frame_sync_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_result_valid"}, result_valid_a, 0);
        chk({tag, "_result_index"}, result_index_a, 0);
        chk({tag, "_result_value"}, result_value_a, 0);
        chk({tag, "_frame_count"}, frame_count_a, 0);
        chk({tag, "_rom_addr"}, rom_addr_a, 0);
    endtask

    int base;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; auto_run_a = 1'b0; pat_sel_a = 2'd0;
        start_b = 1'b0; auto_run_b = 1'b0; pat_sel_b = 2'd0;
        step(3);
        chk_a_zero("reset");
        chk("reset_b_busy", busy_b, 0);
        rst_n = 1'b1;
        step(2);

        // T1/T2: single frame, pattern 0, capture 5/A3 then hold while idle
        base = cyc;
        push_bytes(base, 2'd0, 32);
        push_res_a(base + 37, 4'd5, 8'hA3, 16'd1);
        pat_sel_a = 2'd0;
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_until(base + 38);
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 0) begin
                chk("hold_index", result_index_a, 4'd5);
                chk("hold_value", result_value_a, 8'hA3);
                chk("hold_busy", busy_a, 0);
            end
            step(1);
        end
        chk("t1_frame_count", frame_count_a, 16'd1);

        // T3: three back-to-back frames, select changes latched per frame
        base = cyc;
        pat_sel_a = 2'd1;
        auto_run_a = 1'b1;
        start_a = 1'b1;
        push_bytes(base, 2'd1, 32);
        push_bytes(base + 37, 2'd2, 32);
        push_bytes(base + 74, 2'd3, 32);
        push_res_a(base + 37, 4'd6, 8'h11, 16'd2);
        push_res_a(base + 74, 4'd7, 8'h22, 16'd3);
        push_res_a(base + 111, 4'd8, 8'h33, 16'd4);
        step(1);
        start_a = 1'b0;
        pat_sel_a = 2'd2;
        wait_until(base + 37);
        chk("t3_busy_cap1", busy_a, 1);
        wait_until(base + 50);
        pat_sel_a = 2'd3;
        wait_until(base + 74);
        chk("t3_busy_cap2", busy_a, 1);
        wait_until(base + 80);
        auto_run_a = 1'b0;
        wait_until(base + 111);
        chk("t3_busy_cap3", busy_a, 1);
        step(1);
        chk("t3_idle_after", busy_a, 0);
        chk("t3_frame_count", frame_count_a, 16'd4);
        step(5);

        // T4: start held and pat_sel toggled during the stream
        base = cyc;
        pat_sel_a = 2'd2;
        start_a = 1'b1;
        push_bytes(base, 2'd2, 32);
        push_res_a(base + 37, 4'd9, 8'h44, 16'd5);
        wait_until(base + 2);
        while (cyc <= base + 33) begin
            chk("t4_rom_sel", rom_addr_a[6:5], 2'd2);
            pat_sel_a = ~pat_sel_a;
            if (cyc == base + 30) start_a = 1'b0;
            step(1);
        end
        wait_until(base + 40);
        chk("t4_idle", busy_a, 0);

        // T5: reset in the middle of the stream
        base = cyc;
        pat_sel_a = 2'd3;
        start_a = 1'b1;
        push_bytes(base, 2'd3, 18);
        step(1);
        start_a = 1'b0;
        wait_until(base + 20);
        rst_n = 1'b0;
        step(1);
        chk_a_zero("midreset");
        rst_n = 1'b1;
        step(45);
        chk("t5_stays_idle", busy_a, 0);

        // T6: latency 5 instance, frame counter wrap
        force dut_b.frame_cnt = 16'hFFFF;
        step(1);
        release dut_b.frame_cnt;
        step(1);
        chk("t6_preload", frame_count_b, 16'hFFFF);
        base = cyc;
        pat_sel_b = 2'd1;
        start_b = 1'b1;
        push_res_b(base + 40, 4'hC, 8'h5A, 16'h0000);
        step(1);
        start_b = 1'b0;
        wait_until(base + 3);
        chk("t6_first_byte", {core_frame_sync_b, core_data_b}, {1'b1, 8'h41});
        wait_until(base + 45);
        chk("t6_idle", busy_b, 0);
        chk("t6_wrap", frame_count_b, 16'h0000);

        step(2);
        chk("bytes_left", byte_q.size(), 0);
        chk("results_a_left", res_q_a.size(), 0);
        chk("results_b_left", res_q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
